ws2811_encoder: RTL and testbench



---
 rtl/ws2811_encoder.sv | 160 ++++++++++++++++
 tb/tb_ws2811_encoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2811_encoder.sv
// WS2811 serial encoder: pops colour bytes from a non-show-ahead FIFO and
// shifts each one out MSB-first as cycle-counted high/low bit cells. The next
// byte is prefetched during the last bit so back-to-back bytes have no gap.
// A FIFO that stays empty for TRESET cycles ends the frame with a latch pulse.
module ws2811_encoder #(
  parameter int T0H    = 13,
  parameter int T1H    = 30,
  parameter int TBIT   = 62,
  parameter int TRESET = 2600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifo_q,
  input  logic       fifo_empty,
  output logic       fifo_rdreq,
  output logic       ws2811,
  output logic       busy,
  output logic       latched
);

  localparam int BW = $clog2(TBIT);
  localparam int GW = $clog2(TRESET);

  localparam logic [BW-1:0] BIT_LAST = BW'(TBIT - 1);
  localparam logic [BW-1:0] T0H_C    = BW'(T0H);
  localparam logic [BW-1:0] T1H_C    = BW'(T1H);
  localparam logic [GW-1:0] GAP_LAST = GW'(TRESET - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      next_q, next_d;
  logic            have_next_q, have_next_d;
  logic            pf_pend_q, pf_pend_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            ws_q, ws_d;
  logic            latched_q, latched_d;
  logic            rdreq;

  // Next-state, counters, pop requests and the next value of the data line.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    next_d      = next_q;
    have_next_d = have_next_q;
    pf_pend_d   = 1'b0;
    bit_idx_d   = bit_idx_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    latched_d   = 1'b0;
    rdreq       = 1'b0;

    // Prefetched data arrives one cycle after its pop request.
    if (pf_pend_q) begin
      next_d      = fifo_q;
      have_next_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rdreq   = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        shift_d   = fifo_q;
        bit_idx_d = 3'd7;
        bit_cnt_d = '0;
        state_d   = SEND;
      end

      SEND: begin
        // Only one prefetch window per byte: the first cycle of bit 0.
        if (bit_idx_q == 3'd0 && bit_cnt_q == '0 && !fifo_empty && !have_next_q) begin
          rdreq     = 1'b1;
          pf_pend_d = 1'b1;
        end
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
          end else if (have_next_q) begin
            shift_d     = next_q;
            have_next_d = 1'b0;
            bit_idx_d   = 3'd7;
          end else begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end

      GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        // The latch wins over a byte that shows up on the final gap cycle.
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          latched_d = 1'b1;
          state_d   = IDLE;
        end else if (!fifo_empty) begin
          rdreq   = 1'b1;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Line level for the coming cycle, so the output is a clean register.
    ws_d = (state_d == SEND) &&
           (bit_cnt_d < (shift_d[bit_idx_d] ? T1H_C : T0H_C));
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      next_q      <= '0;
      have_next_q <= 1'b0;
      pf_pend_q   <= 1'b0;
      bit_idx_q   <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ws_q        <= 1'b0;
      latched_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      next_q      <= next_d;
      have_next_q <= have_next_d;
      pf_pend_q   <= pf_pend_d;
      bit_idx_q   <= bit_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ws_q        <= ws_d;
      latched_q   <= latched_d;
    end
  end

  assign fifo_rdreq = rdreq;
  assign ws2811     = ws_q;
  assign busy       = (state_q != IDLE);
  assign latched    = latched_q;

endmodule

// File: tb/tb_ws2811_encoder.sv
// Bench for ws2811_encoder: a queue-backed FIFO model feeds random and fixed
// bytes; a per-cycle monitor logs pop requests, high pulses and latch pulses,
// which are then compared against cell timings computed from the bit rules.
module tb_ws2811_encoder;

  localparam int T0H    = 13;
  localparam int T1H    = 30;
  localparam int TBIT   = 62;
  localparam int TRESET = 2600;

  typedef byte unsigned bq_t[$];
  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_q = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rdreq;
  logic       ws2811;
  logic       busy;
  logic       latched;

  ws2811_encoder #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_q(fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .ws2811(ws2811),
    .busy(busy),
    .latched(latched)
  );

  // 100 MHz-style bench clock; only cycle counts matter.
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  byte unsigned fq[$];
  int rd_log[$];
  int rise_log[$];
  int width_log[$];
  int latch_log[$];
  int busy_cycles = 0;
  int rise_c = 0;
  logic prev_ws = 1'b0;
  logic prev_rd = 1'b0;
  logic prev_busy = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int bitw(input logic [7:0] b, input int j);
    return b[7-j] ? T1H : T0H;
  endfunction

  // One clock cycle: sample at the falling edge, then act as the FIFO.
  task automatic step();
    logic rd;
    @(negedge clk);
    rd = fifo_rdreq;
    if (rd === 1'b1) begin
      chk("rdreq_while_empty", int'(fifo_empty), 0);
      chk("rdreq_back_to_back", int'(prev_rd), 0);
      rd_log.push_back(cyc);
    end
    if (ws2811 === 1'b1 && !prev_ws) begin
      rise_c = cyc;
      rise_log.push_back(cyc);
    end
    if (ws2811 === 1'b0 && prev_ws) width_log.push_back(cyc - rise_c);
    if (latched === 1'b1) begin
      latch_log.push_back(cyc);
      chk("busy_low_at_latch", int'(busy), 0);
      chk("busy_high_before_latch", int'(prev_busy), 1);
    end
    if (busy === 1'b1) busy_cycles++;
    prev_ws   = (ws2811 === 1'b1);
    prev_rd   = (rd === 1'b1);
    prev_busy = (busy === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    if (rd === 1'b1 && fq.size() > 0) fifo_q = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push(input byte unsigned b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    rise_log.delete();
    width_log.delete();
    latch_log.delete();
    busy_cycles = 0;
  endtask

  // Compare every logged cell with its expected start cycle and high width.
  task automatic check_cells(input string tag, input bq_t bytes, input iq_t starts);
    int n;
    n = bytes.size();
    chk({tag, "_cells"}, rise_log.size(), 8 * n);
    chk({tag, "_pulses"}, width_log.size(), 8 * n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = 8 * k + j;
        if (idx < rise_log.size())
          chk($sformatf("%s_start[%0d]", tag, idx), rise_log[idx], starts[k] + j * TBIT);
        if (idx < width_log.size())
          chk($sformatf("%s_high[%0d]", tag, idx), width_log[idx], bitw(bytes[k], j));
      end
    end
    if (latch_log.size() > 0)
      chk({tag, "_latch_at"}, latch_log[latch_log.size()-1],
          starts[n-1] + 8 * TBIT + TRESET);
  endtask

  // Bytes preloaded together must stream as one contiguous run of cells.
  task automatic run_burst(input string tag, input bq_t bytes);
    int p;
    int n;
    iq_t starts;
    clear_logs();
    n = bytes.size();
    p = cyc;
    foreach (bytes[k]) push(bytes[k]);
    run(8 * TBIT * n + TRESET + 40);
    for (int k = 0; k < n; k++) starts.push_back(p + 2 + 8 * TBIT * k);
    chk({tag, "_rdreqs"}, rd_log.size(), n);
    if (rd_log.size() > 0) chk({tag, "_first_rd"}, rd_log[0], p);
    for (int k = 1; k < n && k < rd_log.size(); k++)
      chk($sformatf("%s_prefetch_rd[%0d]", tag, k), rd_log[k], starts[k] - TBIT);
    chk({tag, "_latches"}, latch_log.size(), 1);
    check_cells(tag, bytes, starts);
  endtask

  // Second byte appears 'delay' cycles into the gap after the first byte.
  task automatic gap_test(input string tag, input int delay);
    int p;
    int end_c;
    int pb;
    int exp_rd1;
    int between;
    bq_t bytes;
    iq_t starts;
    clear_logs();
    bytes.push_back(8'($urandom));
    bytes.push_back(8'($urandom));
    p = cyc;
    push(bytes[0]);
    end_c = p + 2 + 8 * TBIT;
    while (cyc < end_c + delay) step();
    pb = cyc;
    push(bytes[1]);
    run(8 * TBIT + TRESET + 40);
    between = (delay >= TRESET - 1) ? 1 : 0;
    exp_rd1 = between ? end_c + TRESET : pb;
    chk({tag, "_rdreqs"}, rd_log.size(), 2);
    if (rd_log.size() > 0) chk({tag, "_rd0"}, rd_log[0], p);
    if (rd_log.size() > 1) chk({tag, "_rd1"}, rd_log[1], exp_rd1);
    chk({tag, "_latches"}, latch_log.size(), 1 + between);
    if (between && latch_log.size() > 0) chk({tag, "_latch0_at"}, latch_log[0], end_c + TRESET);
    starts.push_back(p + 2);
    starts.push_back(exp_rd1 + 2);
    check_cells(tag, bytes, starts);
  endtask

  initial begin
    bq_t b;
    int p;
    int c0;

    // Reset state while reset is held.
    run(3);
    chk("rst_ws2811", int'(ws2811), 0);
    chk("rst_rdreq", int'(fifo_rdreq), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_latched", int'(latched), 0);
    reset = 1'b0;

    // Empty FIFO for a long time: nothing happens.
    clear_logs();
    run(5000);
    chk("idle_rdreqs", rd_log.size(), 0);
    chk("idle_pulses", rise_log.size(), 0);
    chk("idle_latches", latch_log.size(), 0);
    chk("idle_busy_cycles", busy_cycles, 0);
    chk("idle_ws2811", int'(ws2811), 0);

    b.delete();
    b.push_back(8'hA5);
    run_burst("single_a5", b);

    b.delete();
    b.push_back(8'hFF);
    b.push_back(8'h00);
    b.push_back(8'h81);
    run_burst("three", b);

    b.delete();
    for (int k = 0; k < int'($urandom_range(2, 5)); k++) b.push_back(8'($urandom));
    run_burst("rand_burst", b);

    gap_test("underrun", 100);
    gap_test("gap_before_edge", TRESET - 2);
    gap_test("gap_edge", TRESET - 1);

    // Reset during bit 0 of the second byte while the third is prefetched.
    clear_logs();
    p = cyc;
    push(8'($urandom));
    push(8'($urandom));
    push(8'($urandom));
    c0 = p + 2 + 8 * TBIT + 7 * TBIT;
    while (cyc < c0 + 6) step();
    chk("midrst_rdreqs", rd_log.size(), 3);
    chk("midrst_pre_ws2811", int'(ws2811), 1);
    chk("midrst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("midrst_ws2811", int'(ws2811), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_latched", int'(latched), 0);
    step();
    reset = 1'b0;
    clear_logs();
    run(TRESET + 200);
    chk("postrst_latches", latch_log.size(), 0);
    chk("postrst_pulses", rise_log.size(), 0);
    chk("postrst_rdreqs", rd_log.size(), 0);
    chk("postrst_busy_cycles", busy_cycles, 0);

    b.delete();
    b.push_back(8'($urandom));
    run_burst("after_reset", b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
